// File: rtl/multiword_add_seq.sv
// Multi-precision adder sequencer: streams operand words LS-first through an external
// combinational n_bit_adder. Define MULTIWORD_ADD_OVF_EN to enable the signed-overflow flag.
module multiword_add_seq #(
  parameter int n     = 8,
  parameter int WORDS = 4,
  parameter int CW    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_num1,
  input  logic [n-1:0] in_num2,
  input  logic         in_first,
  input  logic         in_last,
  output logic [n-1:0] add_num1,
  output logic [n-1:0] add_num2,
  output logic         add_carry_in,
  input  logic [n-1:0] add_sum,
  input  logic         add_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_sum,
  output logic         out_last,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         err,
  input  logic         err_clr
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic          s1_valid_q;
  logic          s1_first_q;
  logic          s1_last_q;
  logic [n-1:0]  num1_q;
  logic [n-1:0]  num2_q;
  logic          carry_q;

  logic          out_valid_q;
  logic [n-1:0]  out_sum_q;
  logic          out_last_q;
  logic          out_carry_q;

  logic          s1_advance;
  logic          accept;
  logic          word_first_d;
  logic          word_last_d;
  logic          forced_d;
  logic          err_set_d;

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;

  // A word outside an open operation always starts one, even without in_first.
  always_comb begin
    word_first_d = (state_q == IDLE) || in_first;
    forced_d     = !word_first_d && !in_last && (cnt_q == CW'(WORDS - 1));
    word_last_d  = in_last || forced_d;
    err_set_d    = accept && (((state_q == IDLE) && !in_first) ||
                              ((state_q == BUSY) && in_first)  ||
                              forced_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (word_last_d) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= BUSY;
          cnt_q   <= word_first_d ? CW'(1) : cnt_q + CW'(1);
        end
      end
      if (err_set_d) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      num1_q     <= '0;
      num2_q     <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_first_q <= word_first_d;
      s1_last_q  <= word_last_d;
      num1_q     <= in_num1;
      num2_q     <= in_num2;
    end else if (s1_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // The carry is captured as the word leaves S1, ready for the next word of the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else if (s1_advance) begin
      carry_q     <= add_carry;
      out_valid_q <= 1'b1;
      out_sum_q   <= add_sum;
      out_last_q  <= s1_last_q;
      out_carry_q <= s1_last_q && add_carry;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MULTIWORD_ADD_OVF_EN
  logic out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf_q <= 1'b0;
    end else if (s1_advance) begin
      out_ovf_q <= s1_last_q && (num1_q[n-1] == num2_q[n-1]) &&
                   (add_sum[n-1] != num1_q[n-1]);
    end
  end

  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign add_num1     = num1_q;
  assign add_num2     = num2_q;
  assign add_carry_in = s1_first_q ? 1'b0 : carry_q;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed cases plus random streams checked against an
// integer-arithmetic model of each operation; the external adder is modelled here.
module tb_multiword_add_seq;
  localparam int N     = 8;
  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_num1 = '0;
  logic [N-1:0] in_num2 = '0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic [N-1:0] add_num1;
  logic [N-1:0] add_num2;
  logic         add_carry_in;
  logic [N-1:0] add_sum;
  logic         add_carry;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_sum;
  logic         out_last;
  logic         out_carry;
  logic         out_ovf;
  logic         err;
  logic         err_clr = 1'b0;

  logic [N:0]   adder_res;

  multiword_add_seq #(.n(N), .WORDS(WORDS), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2),
    .in_first(in_first), .in_last(in_last),
    .add_num1(add_num1), .add_num2(add_num2), .add_carry_in(add_carry_in),
    .add_sum(add_sum), .add_carry(add_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf),
    .err(err), .err_clr(err_clr)
  );

  // Combinational n_bit_adder
  assign adder_res = {1'b0, add_num1} + {1'b0, add_num2} + {{N{1'b0}}, add_carry_in};
  assign add_sum   = adder_res[N-1:0];
  assign add_carry = adder_res[N];

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     chk_lat  = 1'b0;
  bit     rand_rdy = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] sum;
    bit         last;
    bit         carry;
    bit         ovf;
    longint     acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_open = 1'b0;
  int          m_k    = 0;
  logic [63:0] m_a    = '0;
  logic [63:0] m_b    = '0;
  bit          m_err  = 1'b0;

  // Each emitted word is a byte of the integer sum of the operation's operands so far.
  function automatic void model_word(input logic [7:0] a, input logic [7:0] b,
                                     input bit first, input bit last, input longint c);
    exp_t        e;
    logic [63:0] s;
    bit          new_op;
    bit          forced;
    int          p;
    new_op = !m_open || first;
    if ((!m_open && !first) || (m_open && first)) m_err = 1'b1;
    if (new_op) begin
      m_k = 0;
      m_a = '0;
      m_b = '0;
    end
    m_a = m_a | (64'(a) << (8 * m_k));
    m_b = m_b | (64'(b) << (8 * m_k));
    s = m_a + m_b;
    forced = !new_op && !last && (m_k == WORDS - 1);
    if (forced) m_err = 1'b1;
    p = 8 * m_k + 7;
    e.sum   = s[8*m_k +: 8];
    e.last  = last || forced;
    e.carry = e.last ? s[8*(m_k+1)] : 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
    e.ovf   = e.last && (m_a[p] == m_b[p]) && (s[p] != m_a[p]);
`else
    e.ovf   = 1'b0;
`endif
    e.acc_cyc = c;
    exp_q.push_back(e);
    if (e.last) begin
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
      m_k++;
    end
  endfunction

  // ---------------- output monitor ----------------
  exp_t       mon_e;
  bit         hold_prev = 1'b0;
  logic [7:0] h_sum;
  logic       h_last, h_carry, h_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_val("hold_valid", out_valid, 1'b1);
        check_val("hold_sum", out_sum, h_sum);
        check_val("hold_last", out_last, h_last);
        check_val("hold_carry", out_carry, h_carry);
        check_val("hold_ovf", out_ovf, h_ovf);
      end
      hold_prev = out_valid && !out_ready;
      h_sum = out_sum; h_last = out_last; h_carry = out_carry; h_ovf = out_ovf;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("out_sum", out_sum, mon_e.sum);
          check_val("out_last", out_last, mon_e.last);
          check_val("out_carry", out_carry, mon_e.carry);
          check_val("out_ovf", out_ovf, mon_e.ovf);
          if (chk_lat) check_val("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input bit first, input bit last);
    int guard;
    in_valid = 1'b1; in_num1 = a; in_num2 = b; in_first = first; in_last = last;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (in_ready) model_word(a, b, first, last, cyc);
    else check_val("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_err = 1'b0;
    check_val("err_after_clr", err, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_last", out_last, 1'b0);
    check_val("rst_out_carry", out_carry, 1'b0);
    check_val("rst_out_ovf", out_ovf, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_out_sum", out_sum, 8'h00);
    check_val("rst_add_num1", add_num1, 8'h00);
    check_val("rst_add_num2", add_num2, 8'h00);
    check_val("rst_add_carry_in", add_carry_in, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x01FF + 0x0001
    chk_lat = 1'b1;
    send_word(8'hFF, 8'h01, 1'b1, 1'b0);
    send_word(8'h01, 8'h00, 1'b0, 1'b1);
    drain();
    check_val("t1_err", err, 1'b0);

    // 0xFFFFFFFF + 0x00000001, back to back
    send_word(8'hFF, 8'h01, 1'b1, 1'b0);
    send_word(8'hFF, 8'h00, 1'b0, 1'b0);
    send_word(8'hFF, 8'h00, 1'b0, 1'b0);
    send_word(8'hFF, 8'h00, 1'b0, 1'b1);
    drain();
    chk_lat = 1'b0;

    // Same stream with a 3-cycle output stall mid-operation
    fork
      begin
        send_word(8'hFF, 8'h01, 1'b1, 1'b0);
        send_word(8'hFF, 8'h00, 1'b0, 1'b0);
        send_word(8'hFF, 8'h00, 1'b0, 1'b0);
        send_word(8'hFF, 8'h00, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("stall_in_ready", in_ready, 1'b0);
        check_val("stall_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // New operation started while BUSY
    send_word(8'h11, 8'h22, 1'b1, 1'b0);
    send_word(8'h33, 8'h44, 1'b1, 1'b0);
    check_val("restart_err", err, 1'b1);
    send_word(8'h55, 8'h66, 1'b0, 1'b1);
    drain();
    clear_err();

    // Five words, never in_last: word 4 forced last, word 5 opens a new op
    send_word(8'h10, 8'h01, 1'b1, 1'b0);
    send_word(8'h20, 8'h02, 1'b0, 1'b0);
    send_word(8'h30, 8'h03, 1'b0, 1'b0);
    send_word(8'hF0, 8'h20, 1'b0, 1'b0);
    check_val("forced_err", err, 1'b1);
    send_word(8'h50, 8'h05, 1'b0, 1'b0);
    check_val("forced_err_held", err, 1'b1);
    send_word(8'h60, 8'h06, 1'b0, 1'b1);
    drain();
    clear_err();

    // Single-word signed overflow
    send_word(8'h7F, 8'h01, 1'b1, 1'b1);
    drain();

    // Reset mid-operation discards in-flight words
    send_word(8'hAA, 8'h55, 1'b1, 1'b0);
    send_word(8'hAA, 8'h55, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_in_ready", in_ready, 1'b1);
    check_val("midrst_add_num1", add_num1, 8'h00);
    exp_q.delete();
    m_open = 1'b0;
    m_err  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h80, 8'h80, 1'b1, 1'b0);
    send_word(8'h01, 8'h02, 1'b0, 1'b1);
    drain();
    check_val("midrst_err", err, 1'b0);

    // Random streams with backpressure, gaps and occasional protocol errors
    rand_rdy = 1'b1;
    for (int op = 0; op < 150; op++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int w = 0; w < len; w++) begin
        bit f, l;
        f = (w == 0);
        l = (w == len - 1) && (len != 5);
        if ($urandom_range(0, 19) == 0) f = !f;
        if ($urandom_range(0, 19) == 0) l = !l;
        send_word(8'($urandom), 8'($urandom), f, l);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check_val("rand_err", err, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
